// File: rtl/ft_add_pkg.sv
// ---------------------------------------------------------------------------
// ft_add_pkg
// Shared definitions for the fault-tolerant adder controller:
//   - state_t        : controller FSM states
//   - DEF_WIDTH      : default operand / sum width
//   - DEF_MAX_RETRY  : default number of re-executions after the first mismatch
//   - retry_w()      : width of a retry counter able to hold 0..max_retry
//   - DEF_RETRY_W    : retry counter width for the default MAX_RETRY
// ---------------------------------------------------------------------------
package ft_add_pkg;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_MAX_RETRY = 3;

   function automatic int retry_w(input int max_retry);
      return $clog2(max_retry + 1);
   endfunction

   localparam int DEF_RETRY_W = $clog2(DEF_MAX_RETRY + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/ft_add_fsm.sv
// ---------------------------------------------------------------------------
// ft_add_fsm
// Transaction sequencer for the duplicated adder. Owns the state register and
// the retry counter; emits strobes that the top uses to load its registers.
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : request pending at the input
//   out_ready   : consumer accepts the result (only meaningful in DONE)
//   mismatch    : primary and shadow adder results differ (combinational)
//   in_ready    : high exactly in IDLE
//   out_valid   : high exactly in DONE
//   accept      : IDLE with a request -> capture operands this edge
//   load_out    : CHECK finishing -> capture result this edge
//   check_miss  : CHECK cycle with disagreeing copies (one per attempt)
// ---------------------------------------------------------------------------
module ft_add_fsm
   import ft_add_pkg::*;
#(
   parameter int MAX_RETRY = DEF_MAX_RETRY,
   localparam int RW       = retry_w(MAX_RETRY)
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic out_ready,
   input  logic mismatch,
   output logic in_ready,
   output logic out_valid,
   output logic accept,
   output logic load_out,
   output logic check_miss
);

   state_t          state;
   logic [RW-1:0]   retry_cnt;
   logic            retry_done;

   // All retries consumed: the next mismatch is reported instead of retried.
   assign retry_done = (retry_cnt == RW'(MAX_RETRY));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         retry_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state     <= EXEC;
                  retry_cnt <= '0;
               end
            end
            // One cycle for the adder copies to settle on the new operands.
            EXEC: state <= CHECK;
            CHECK: begin
               if (mismatch && !retry_done) begin
                  retry_cnt <= retry_cnt + RW'(1);
                  state     <= EXEC;
               end else begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign accept     = (state == IDLE) && in_valid;
   assign load_out   = (state == CHECK) && (!mismatch || retry_done);
   assign check_miss = (state == CHECK) && mismatch;

endmodule

// File: rtl/ft_add_ctrl.sv
// ---------------------------------------------------------------------------
// ft_add_ctrl
// Controller for a duplicated (primary + shadow) external adder. Captures a
// request, drives both adder copies from one set of registered operands,
// compares their results and re-executes on disagreement up to MAX_RETRY
// times. The result is always taken from the primary copy; out_fault flags a
// result produced while the copies still disagreed.
//
// Optional feature: define FT_ADD_ERRCNT_EN to add the err_cnt port, an 8-bit
// saturating count of every mismatching compare (retries included).
//
// Ports
//   clk, rst                  : clock, asynchronous active-high reset
//   in_valid/in_ready         : request handshake
//   in_a, in_b, in_cin        : request operands
//   op_a, op_b, op_cin        : registered operands to both adder copies
//   sum0/cout0, sum1/cout1    : primary / shadow adder results
//   out_valid/out_ready       : result handshake
//   out_sum, out_cout         : registered result from the primary copy
//   out_fault                 : result delivered with copies disagreeing
//   err_cnt                   : mismatch counter (FT_ADD_ERRCNT_EN only)
// ---------------------------------------------------------------------------
module ft_add_ctrl
   import ft_add_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int MAX_RETRY = DEF_MAX_RETRY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             op_cin,
   input  logic [WIDTH-1:0] sum0,
   input  logic [WIDTH-1:0] sum1,
   input  logic             cout0,
   input  logic             cout1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_fault
`ifdef FT_ADD_ERRCNT_EN
   ,
   output logic [7:0]       err_cnt
`endif
);

   logic mismatch;
   logic accept;
   logic load_out;
   logic check_miss;

   // Carry-out is part of the compared word so a carry-only upset is caught.
   assign mismatch = ({cout0, sum0} != {cout1, sum1});

   ft_add_fsm #(
      .MAX_RETRY (MAX_RETRY)
   ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .out_ready  (out_ready),
      .mismatch   (mismatch),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .accept     (accept),
      .load_out   (load_out),
      .check_miss (check_miss)
   );

   // Operands only load on acceptance, so retries re-run the same inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a   <= '0;
         op_b   <= '0;
         op_cin <= 1'b0;
      end else if (accept) begin
         op_a   <= in_a;
         op_b   <= in_b;
         op_cin <= in_cin;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_sum   <= '0;
         out_cout  <= 1'b0;
         out_fault <= 1'b0;
      end else if (load_out) begin
         out_sum   <= sum0;
         out_cout  <= cout0;
         out_fault <= mismatch;
      end
   end

`ifdef FT_ADD_ERRCNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= 8'd0;
      end else if (check_miss && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`else
   // check_miss only feeds the optional counter.
   logic unused_check_miss;
   assign unused_check_miss = check_miss;
`endif

endmodule
